// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider controller: one shared negation unit, fixed latency,
// signed/unsigned truncating division with start/busy/done handshake.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle, StNegA, StNegB, StIter, StFixQ, StFixR, StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic             sa_q, sb_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH-1:0] neg_in, neg_out;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;

  // Shared two's-complement negation unit, one operand per state.
  always_comb begin
    neg_in = '0;
    unique case (state_q)
      StNegA:  neg_in = a_q;
      StNegB:  neg_in = b_q;
      StFixQ:  neg_in = a_q;
      StFixR:  neg_in = r_q;
      default: neg_in = '0;
    endcase
    neg_out = ~neg_in + WIDTH'(1);
  end

  // Restoring step: shifted partial remainder needs WIDTH+1 bits before the compare.
  always_comb begin
    shifted = {r_q, a_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    ge      = ~diff[WIDTH+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      r_q         <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q         <= dividend;
            b_q         <= divisor;
            sa_q        <= signed_mode & dividend[WIDTH-1];
            sb_q        <= signed_mode & divisor[WIDTH-1];
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Route through FIXR with an unsigned pass-through so remainder = dividend.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              r_q         <= dividend;
              sa_q        <= 1'b0;
              state_q     <= StFixR;
            end else begin
              state_q <= StNegA;
            end
          end
        end
        StNegA: begin
          if (sa_q) a_q <= neg_out;
          state_q <= StNegB;
        end
        StNegB: begin
          if (sb_q) b_q <= neg_out;
          r_q     <= '0;
          cnt_q   <= '0;
          state_q <= StIter;
        end
        StIter: begin
          a_q   <= {a_q[WIDTH-2:0], ge};
          r_q   <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFixQ;
        end
        StFixQ: begin
          quotient <= (sa_q ^ sb_q) ? neg_out : a_q;
          state_q  <= StFixR;
        end
        StFixR: begin
          remainder <= sa_q ? neg_out : r_q;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: driver pushes expected results, monitor checks on done.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  div_seq_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          cyc;
    int          busy_n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts busy cycles and compares results whenever done pulses.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", int'(quotient), int'(e.q));
          chk("remainder", int'(remainder), int'(e.r));
          chk("div_by_zero", int'(div_by_zero), int'(e.dz));
          chk("done_cycle", cyc, e.cyc);
          chk("busy_cycles", busy_cnt, e.busy_n);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] dd, input logic [15:0] dv, input logic sm,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz);
    exp_t e;
    @(negedge clk);
    dividend    = dd;
    divisor     = dv;
    signed_mode = sm;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    e.q      = eq;
    e.r      = er;
    e.dz     = edz;
    e.busy_n = edz ? 1 : 20;
    e.cyc    = cyc + e.busy_n;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else @(negedge clk);
    end
    chk("done_timeout", int'(seen), 1);
  endtask

  task automatic run(input logic [15:0] dd, input logic [15:0] dv, input logic sm,
                     input logic [15:0] eq, input logic [15:0] er, input logic edz);
    issue(dd, dv, sm, eq, er, edz);
    wait_done();
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;

    run(16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0);
    run(16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0);
    run(16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0);
    run(16'hFFF9, 16'h0002, 1'b0, 16'h7FFC, 16'h0001, 1'b0);
    run(16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0);
    run(16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1);
    run(16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0);
    run(16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0);
    run(16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0);

    // Starts during ITER and in the DONE cycle must be ignored.
    issue(16'd1000, 16'd3, 1'b0, 16'h014D, 16'h0001, 1'b0);
    repeat (8) @(negedge clk);
    dividend = 16'h0050; divisor = 16'h0005; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    dividend = 16'h0063; divisor = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_ignored_busy", int'(busy), 0);
    chk("idle_after_ignored_q", int'(quotient), 16'h014D);
    chk("idle_after_ignored_dbz", int'(div_by_zero), 0);

    // Asynchronous reset during ITER aborts the operation.
    issue(16'h4000, 16'h0003, 1'b0, 16'h1555, 16'h0001, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_quotient", int'(quotient), 0);
    chk("arst_remainder", int'(remainder), 0);
    chk("arst_dbz", int'(div_by_zero), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(16'd200, 16'd10, 1'b0, 16'h0014, 16'h0000, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
